// File: rtl/stage_mem_lsu.sv
// Memory stage load/store unit: request/acknowledge bus master with a registered
// IDLE/BUSY FSM, byte-lane steering, misalignment detection and registered writeback.
module stage_mem_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [4:0]        reg_waddr_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   reg_wdata_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [XLEN-1:0]   rt_data,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_sel_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              valid_o,
    output logic [4:0]        reg_waddr_o,
    output logic              we_o,
    output logic [XLEN-1:0]   reg_wdata_o,
    output logic              misalign_o,
    output logic              stallreq
);

    localparam int NB  = XLEN / 8;
    localparam int OFS = $clog2(NB);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [NB-1:0]       mem_sel_q;
    logic [XLEN-1:0]     mem_wdata_q;
    logic                valid_q;
    logic [4:0]          reg_waddr_q;
    logic                we_q;
    logic [XLEN-1:0]     reg_wdata_q;
    logic                misalign_q;
    logic                cap_rd_q;
    logic                cap_we_q;
    logic                cap_uns_q;
    logic [1:0]          cap_size_q;
    logic [OFS-1:0]      cap_off_q;
    logic [4:0]          cap_waddr_q;
    logic                drop_q;

    logic [OFS-1:0]      off_s;
    logic                mem_op_s;
    logic                mis_s;
    logic                accept_s;
    logic                start_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = a[0];
            2'd2:    r = |a[1:0];
            2'd3:    r = (XLEN == 32) || (|a);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [NB-1:0] lane_sel(input logic [1:0] size, input logic [OFS-1:0] off);
        logic [NB-1:0] r;
        case (size)
            2'd0:    r = NB'(1'b1) << off;
            2'd1:    r = NB'(2'b11) << off;
            2'd2:    r = NB'(4'hF) << off;
            default: r = {NB{1'b1}};
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [XLEN-1:0] rt);
        logic [XLEN-1:0] r;
        case (size)
            2'd0:    r = {NB{rt[7:0]}};
            2'd1:    r = {(NB/2){rt[15:0]}};
            2'd2:    r = {(NB/4){rt[31:0]}};
            default: r = rt;
        endcase
        return r;
    endfunction

    // Lane data is shifted down to bit 0 first, then sign- or zero-extended by size.
    function automatic logic [XLEN-1:0] load_ext(input logic [1:0] size, input logic uns,
                                                 input logic [OFS-1:0] off,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'd0: begin
                if (uns) r = XLEN'(sh[7:0]);
                else     r = XLEN'($signed(sh[7:0]));
            end
            2'd1: begin
                if (uns) r = XLEN'(sh[15:0]);
                else     r = XLEN'($signed(sh[15:0]));
            end
            2'd2: begin
                if (uns) r = XLEN'(sh[31:0]);
                else     r = XLEN'($signed(sh[31:0]));
            end
            default: r = sh;
        endcase
        return r;
    endfunction

    // Decode of the incoming instruction while the unit is idle.
    always_comb begin
        off_s    = mem_addr_i[OFS-1:0];
        mem_op_s = mem_rd_i | mem_wr_i;
        mis_s    = is_misaligned(mem_size_i, mem_addr_i[2:0]);
        accept_s = (state_q == IDLE) && valid_i && !flush_i;
        start_s  = accept_s && mem_op_s && !mis_s;
    end

    // Stall covers the accept cycle and every BUSY cycle up to, not including, the ack.
    always_comb begin
        if (state_q == BUSY) begin
            stallreq = !mem_ack_i;
        end else begin
            stallreq = start_s;
        end
    end

    // FSM, bus request registers and writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
            valid_q     <= 1'b0;
            reg_waddr_q <= 5'd0;
            we_q        <= 1'b0;
            reg_wdata_q <= '0;
            misalign_q  <= 1'b0;
            cap_rd_q    <= 1'b0;
            cap_we_q    <= 1'b0;
            cap_uns_q   <= 1'b0;
            cap_size_q  <= 2'd0;
            cap_off_q   <= '0;
            cap_waddr_q <= 5'd0;
            drop_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q    <= 1'b0;
                    we_q       <= 1'b0;
                    misalign_q <= 1'b0;
                    mem_req_q  <= 1'b0;
                    mem_we_q   <= 1'b0;
                    if (accept_s && !mem_op_s) begin
                        valid_q     <= 1'b1;
                        we_q        <= we_i;
                        reg_waddr_q <= reg_waddr_i;
                        reg_wdata_q <= reg_wdata_i;
                    end else if (accept_s && mis_s) begin
                        valid_q     <= 1'b1;
                        misalign_q  <= 1'b1;
                        reg_waddr_q <= reg_waddr_i;
                        reg_wdata_q <= '0;
                    end else if (start_s) begin
                        state_q     <= BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_wr_i;
                        mem_addr_q  <= mem_addr_i & ~ADDR_W'(NB - 1);
                        mem_sel_q   <= lane_sel(mem_size_i, off_s);
                        mem_wdata_q <= lane_wdata(mem_size_i, rt_data);
                        cap_rd_q    <= mem_rd_i;
                        cap_we_q    <= we_i;
                        cap_uns_q   <= mem_unsigned_i;
                        cap_size_q  <= mem_size_i;
                        cap_off_q   <= off_s;
                        cap_waddr_q <= reg_waddr_i;
                        drop_q      <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flush_i) drop_q <= 1'b1;
                    // The bus cycle cannot be cancelled; a flush only suppresses the writeback.
                    if (mem_ack_i) begin
                        state_q     <= IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_sel_q   <= '0;
                        valid_q     <= 1'b1;
                        reg_waddr_q <= cap_waddr_q;
                        if (cap_rd_q && !drop_q && !flush_i) begin
                            we_q        <= cap_we_q;
                            reg_wdata_q <= load_ext(cap_size_q, cap_uns_q, cap_off_q, mem_rdata_i);
                        end else begin
                            we_q        <= 1'b0;
                            reg_wdata_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_sel_o   = mem_sel_q;
    assign mem_wdata_o = mem_wdata_q;
    assign valid_o     = valid_q;
    assign reg_waddr_o = reg_waddr_q;
    assign we_o        = we_q;
    assign reg_wdata_o = reg_wdata_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Directed bench for stage_mem_lsu: one XLEN=32 and one XLEN=64 instance share stimulus,
// expected values are hand-computed per step.
module tb_stage_mem_lsu;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, flush;
    logic [4:0]  waddr;
    logic        we;
    logic [63:0] wdi;
    logic [31:0] maddr;
    logic        rd, wr, uns;
    logic [1:0]  size;
    logic [63:0] rt;
    logic        a_ack, b_ack;
    logic [63:0] rdata;

    logic        a_req, a_mwe, a_vo, a_we, a_mis, a_stall;
    logic [31:0] a_addr, a_wdata, a_rwd;
    logic [3:0]  a_sel;
    logic [4:0]  a_wa;
    logic        b_req, b_mwe, b_vo, b_we, b_mis, b_stall;
    logic [31:0] b_addr;
    logic [63:0] b_wdata, b_rwd;
    logic [7:0]  b_sel;
    logic [4:0]  b_wa;

    bit          use64;
    logic        o_req, o_mwe, o_vo, o_we, o_mis, o_stall;
    logic [31:0] o_addr;
    logic [7:0]  o_sel;
    logic [63:0] o_wdata, o_rwd;
    logic [4:0]  o_wa;

    int errors = 0;
    int checks = 0;

    stage_mem_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .valid_i(a_valid), .flush_i(flush),
        .reg_waddr_i(waddr), .we_i(we), .reg_wdata_i(wdi[31:0]),
        .mem_addr_i(maddr), .mem_rd_i(rd), .mem_wr_i(wr), .mem_size_i(size),
        .mem_unsigned_i(uns), .rt_data(rt[31:0]),
        .mem_req_o(a_req), .mem_we_o(a_mwe), .mem_addr_o(a_addr), .mem_sel_o(a_sel),
        .mem_wdata_o(a_wdata), .mem_ack_i(a_ack), .mem_rdata_i(rdata[31:0]),
        .valid_o(a_vo), .reg_waddr_o(a_wa), .we_o(a_we), .reg_wdata_o(a_rwd),
        .misalign_o(a_mis), .stallreq(a_stall)
    );

    stage_mem_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .valid_i(b_valid), .flush_i(flush),
        .reg_waddr_i(waddr), .we_i(we), .reg_wdata_i(wdi),
        .mem_addr_i(maddr), .mem_rd_i(rd), .mem_wr_i(wr), .mem_size_i(size),
        .mem_unsigned_i(uns), .rt_data(rt),
        .mem_req_o(b_req), .mem_we_o(b_mwe), .mem_addr_o(b_addr), .mem_sel_o(b_sel),
        .mem_wdata_o(b_wdata), .mem_ack_i(b_ack), .mem_rdata_i(rdata),
        .valid_o(b_vo), .reg_waddr_o(b_wa), .we_o(b_we), .reg_wdata_o(b_rwd),
        .misalign_o(b_mis), .stallreq(b_stall)
    );

    always #5 clk = ~clk;

    // Observation mux: selects which instance the checks look at.
    always_comb begin
        o_req   = use64 ? b_req   : a_req;
        o_mwe   = use64 ? b_mwe   : a_mwe;
        o_vo    = use64 ? b_vo    : a_vo;
        o_we    = use64 ? b_we    : a_we;
        o_mis   = use64 ? b_mis   : a_mis;
        o_stall = use64 ? b_stall : a_stall;
        o_addr  = use64 ? b_addr  : a_addr;
        o_sel   = use64 ? b_sel   : {4'h0, a_sel};
        o_wdata = use64 ? b_wdata : {32'h0, a_wdata};
        o_rwd   = use64 ? b_rwd   : {32'h0, a_rwd};
        o_wa    = use64 ? b_wa    : a_wa;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mem(input string tag, input bit b64, input logic [31:0] addr,
                           input logic [1:0] sz, input bit is_rd, input bit is_uns,
                           input logic [63:0] st, input logic [63:0] rdat,
                           input int busy_n, input int flush_at,
                           input logic [31:0] e_addr, input logic [7:0] e_sel,
                           input logic [63:0] e_wdata, input logic [63:0] e_res,
                           input bit chk_res);
        int stalls;
        use64 = b64;
        maddr = addr; size = sz; rd = is_rd; wr = !is_rd; uns = is_uns; rt = st;
        waddr = 5'd9; we = 1'b1;
        if (b64) b_valid = 1'b1;
        else     a_valid = 1'b1;
        stalls = 0;
        #1;
        if (o_stall) stalls++;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        for (int c = 1; c <= busy_n; c++) begin
            chk({tag, "_req"}, {63'd0, o_req}, 64'd1);
            if (c == 1) begin
                chk({tag, "_addr"}, {32'd0, o_addr}, {32'd0, e_addr});
                chk({tag, "_sel"}, {56'd0, o_sel}, {56'd0, e_sel});
                chk({tag, "_wdata"}, o_wdata, e_wdata);
                chk({tag, "_memwe"}, {63'd0, o_mwe}, {63'd0, !is_rd});
            end
            flush = (c == flush_at);
            if (c == busy_n) begin
                a_ack = !b64; b_ack = b64; rdata = rdat;
            end
            #1;
            if (o_stall) stalls++;
            step();
            a_ack = 1'b0; b_ack = 1'b0; flush = 1'b0;
        end
        chk({tag, "_stalls"}, 64'(stalls), 64'(busy_n));
        chk({tag, "_valid"}, {63'd0, o_vo}, 64'd1);
        chk({tag, "_we"}, {63'd0, o_we}, {63'd0, is_rd && (flush_at == 0)});
        chk({tag, "_waddr"}, {59'd0, o_wa}, 64'd9);
        chk({tag, "_mis"}, {63'd0, o_mis}, 64'd0);
        chk({tag, "_reqoff"}, {63'd0, o_req}, 64'd0);
        if (chk_res) chk({tag, "_res"}, o_rwd, e_res);
        step();
        chk({tag, "_pulse"}, {63'd0, o_vo}, 64'd0);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; use64 = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0; waddr = 5'd0; we = 1'b0;
        wdi = 64'd0; maddr = 32'd0; rd = 1'b0; wr = 1'b0; uns = 1'b0; size = 2'd0;
        rt = 64'd0; a_ack = 1'b0; b_ack = 1'b0; rdata = 64'd0;

        #3;
        chk("rst_valid32", {63'd0, a_vo}, 64'd0);
        chk("rst_req32", {63'd0, a_req}, 64'd0);
        chk("rst_rwd32", {32'd0, a_rwd}, 64'd0);
        chk("rst_sel64", {56'd0, b_sel}, 64'd0);
        chk("rst_stall64", {63'd0, b_stall}, 64'd0);
        chk("rst_mis64", {63'd0, b_mis}, 64'd0);
        #4 rst = 1'b0;
        step();

        // ALU pass-through, latency 1, no stall
        use64 = 1'b0;
        a_valid = 1'b1; waddr = 5'd7; we = 1'b1; wdi = 64'h0000_0000_DEAD_BEEF;
        #1 chk("alu_stall", {63'd0, o_stall}, 64'd0);
        step();
        a_valid = 1'b0;
        chk("alu_valid", {63'd0, o_vo}, 64'd1);
        chk("alu_we", {63'd0, o_we}, 64'd1);
        chk("alu_waddr", {59'd0, o_wa}, 64'd7);
        chk("alu_data", o_rwd, 64'h0000_0000_DEAD_BEEF);

        run_mem("lb32", 1'b0, 32'h1003, 2'd0, 1'b1, 1'b0, 64'd0, 64'h80AABBCC, 4, 0,
                32'h1000, 8'h08, 64'h0, 64'h0000_0000_FFFF_FF80, 1'b1);
        run_mem("lbu32", 1'b0, 32'h1003, 2'd0, 1'b1, 1'b1, 64'd0, 64'h80AABBCC, 4, 0,
                32'h1000, 8'h08, 64'h0, 64'h0000_0000_0000_0080, 1'b1);
        run_mem("sh32", 1'b0, 32'h2002, 2'd1, 1'b0, 1'b0, 64'h1234ABCD, 64'd0, 1, 0,
                32'h2000, 8'h0C, 64'h0000_0000_ABCD_ABCD, 64'h0, 1'b1);
        run_mem("ld64", 1'b1, 32'h18, 2'd3, 1'b1, 1'b0, 64'd0, 64'h1122334455667788, 2, 0,
                32'h18, 8'hFF, 64'h0, 64'h1122334455667788, 1'b1);
        run_mem("lw64", 1'b1, 32'h1C, 2'd2, 1'b1, 1'b0, 64'hCAFEBABE_12345678,
                64'h80000001_DEADBEEF, 1, 0,
                32'h18, 8'hF0, 64'h12345678_12345678, 64'hFFFFFFFF_80000001, 1'b1);
        run_mem("sb64", 1'b1, 32'h21, 2'd0, 1'b0, 1'b0, 64'h0000_0000_0000_00AB, 64'd0, 1, 0,
                32'h20, 8'h02, 64'hABABABAB_ABABABAB, 64'h0, 1'b1);
        run_mem("lhu64", 1'b1, 32'h26, 2'd1, 1'b1, 1'b1, 64'd0, 64'hFFEEDDCC_BBAA9988, 2, 0,
                32'h20, 8'hC0, 64'h0, 64'h0000_0000_0000_FFEE, 1'b1);
        run_mem("flw32", 1'b0, 32'h3004, 2'd2, 1'b1, 1'b0, 64'd0, 64'h12345678, 3, 1,
                32'h3004, 8'h0F, 64'h0, 64'h0, 1'b0);

        // Misaligned LW on XLEN=32
        use64 = 1'b0;
        a_valid = 1'b1; maddr = 32'h1002; size = 2'd2; rd = 1'b1; wr = 1'b0; waddr = 5'd4; we = 1'b1;
        #1 chk("mislw_stall", {63'd0, o_stall}, 64'd0);
        step();
        a_valid = 1'b0;
        chk("mislw_req", {63'd0, o_req}, 64'd0);
        chk("mislw_valid", {63'd0, o_vo}, 64'd1);
        chk("mislw_mis", {63'd0, o_mis}, 64'd1);
        chk("mislw_we", {63'd0, o_we}, 64'd0);
        step();

        // SD is illegal on XLEN=32 even when 8-byte aligned
        a_valid = 1'b1; maddr = 32'h1000; size = 2'd3; rd = 1'b0; wr = 1'b1;
        #1 chk("sd32_stall", {63'd0, o_stall}, 64'd0);
        step();
        a_valid = 1'b0;
        chk("sd32_req", {63'd0, o_req}, 64'd0);
        chk("sd32_mis", {63'd0, o_mis}, 64'd1);
        chk("sd32_we", {63'd0, o_we}, 64'd0);
        step();

        // Flush in IDLE suppresses acceptance
        a_valid = 1'b1; flush = 1'b1; rd = 1'b0; wr = 1'b0; wdi = 64'h55;
        step();
        a_valid = 1'b0; flush = 1'b0;
        chk("iflush_valid", {63'd0, o_vo}, 64'd0);

        // Ack in IDLE is ignored
        a_ack = 1'b1; rdata = 64'hFFFF_FFFF;
        step();
        a_ack = 1'b0;
        chk("idleack_valid", {63'd0, o_vo}, 64'd0);
        chk("idleack_req", {63'd0, o_req}, 64'd0);

        // Reset while BUSY abandons the transaction
        a_valid = 1'b1; maddr = 32'h4000; size = 2'd2; rd = 1'b1; wr = 1'b0;
        step();
        a_valid = 1'b0;
        chk("rbusy_req", {63'd0, o_req}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rbusy_req0", {63'd0, o_req}, 64'd0);
        chk("rbusy_sel0", {56'd0, o_sel}, 64'd0);
        chk("rbusy_stall0", {63'd0, o_stall}, 64'd0);
        chk("rbusy_valid0", {63'd0, o_vo}, 64'd0);
        #1 rst = 1'b0;
        a_ack = 1'b1; rdata = 64'h1234;
        step();
        a_ack = 1'b0;
        chk("rbusy_lateack", {63'd0, o_vo}, 64'd0);
        rd = 1'b0; a_valid = 1'b1; waddr = 5'd3; we = 1'b1; wdi = 64'h1357_2468;
        step();
        a_valid = 1'b0;
        chk("rbusy_alu_valid", {63'd0, o_vo}, 64'd1);
        chk("rbusy_alu_data", o_rwd, 64'h1357_2468);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
- Parametrised successor memory stage: performs loads/stores over a request/acknowledge bus with a registered FSM, replacing combinational busy/done tracking.
- Sits between the EX/MEM pipeline register and writeback.
- Generalised to XLEN 32 or 64, including doubleword access and byte lanes.
- Adds misalignment detection, flush of in-flight loads and registered writeback outputs.

Parameters:
- XLEN, 32, datapath/register width; legal values 32 or 64.
- ADDR_W, 32, memory address width.
- NB, XLEN/8, byte lanes (derived, not overridable); OFS = log2(NB).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  instruction present on inputs.
- flush_i  in  1  discard current/in-flight instruction result.
- reg_waddr_i  in  5  destination register.
- we_i  in  1  register write enable.
- reg_wdata_i  in  XLEN  ALU result (non-memory ops).
- mem_addr_i  in  ADDR_W  effective address.
- mem_rd_i  in  1  load.
- mem_wr_i  in  1  store (mem_rd_i and mem_wr_i never both 1).
- mem_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- mem_unsigned_i  in  1  zero-extend load.
- rt_data  in  XLEN  store data.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write.
- mem_addr_o  out  ADDR_W  bus address, aligned down to NB bytes.
- mem_sel_o  out  NB  byte-lane strobes.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_ack_i  in  1  bus acknowledge; read data valid the same cycle.
- mem_rdata_i  in  XLEN  bus read data.
- valid_o  out  1  result valid, one-cycle pulse.
- reg_waddr_o  out  5  writeback address.
- we_o  out  1  writeback enable.
- reg_wdata_o  out  XLEN  writeback data.
- misalign_o  out  1  misaligned/illegal access, pulses with valid_o.
- stallreq  out  1  stall upstream stages.

Behaviour:
- Reset: state IDLE, every output and captured register 0.
- Reset asserted mid-transaction abandons it; no result is produced.
- States:
  - IDLE: accepts input.
  - BUSY: mem_req_o held with registered addr/sel/wdata/we until ack.
- Misaligned access:
  - size1 with addr[0]!=0; size2 with addr[1:0]!=0; size3 with addr[2:0]!=0.
  - size3 when XLEN=32 is also illegal.
  - Result: no bus request; next cycle valid_o=1, misalign_o=1, we_o=0.
- Accept in IDLE (valid_i=1, flush_i=0):
  - Non-memory op: next cycle valid_o=1, reg_waddr_o/we_o/reg_wdata_o = inputs. Latency 1, no stall.
  - Aligned load/store: capture op, go to BUSY. stallreq=1 combinationally this cycle.
- BUSY:
  - stallreq = !mem_ack_i, so stall drops in the ack cycle and upstream advances on that edge.
  - On mem_ack_i, return to IDLE; next cycle valid_o=1.
  - Load: reg_wdata_o = selected lane data, sign- or zero-extended to XLEN per mem_unsigned_i; we_o = captured we.
  - Store: we_o=0, reg_wdata_o=0.
  - Inputs are ignored in BUSY.
- Lanes: off = addr[OFS-1:0].
  - Byte: sel = 1<<off.
  - Half: sel = 2'b11<<off.
  - Word: sel = 4'hF<<off.
  - Dword: all ones.
  - wdata = rt_data low bytes replicated across XLEN.
- Load data: selected bytes taken from mem_rdata_i at byte offset off.
- Flush:
  - IDLE with flush_i: nothing accepted, valid_o=0.
  - BUSY with flush_i: set drop flag; request continues until ack (bus transaction cannot be cancelled); completion then produces valid_o=1 with we_o=0.
- Ack in IDLE is ignored. mem_req_o is never 1 in IDLE.
- Minimum load/store occupancy: accept cycle + 1 BUSY cycle. Back-to-back memory ops re-enter BUSY the cycle after ack.

Test Plan:
- XLEN=32: LB addr 0x1003, rdata 0x80AABBCC, ack after 3 BUSY cycles -> sel 4'b1000, addr 0x1000, stallreq high 4 cycles, reg_wdata_o 0xFFFFFF80; LBU same -> 0x00000080.
- XLEN=32: SH addr 0x2002, rt_data 0x1234ABCD -> sel 4'b1100, wdata 0xABCDABCD, mem_we_o=1, valid_o with we_o=0.
- XLEN=64: LD addr 0x18 -> sel 8'hFF; LW addr 0x1C, rdata upper word 0x8000_0001, signed -> 0xFFFFFFFF80000001.
- Misalignment: LW addr 0x1002 -> no mem_req_o, misalign_o=1, we_o=0, no stall; SD on XLEN=32 -> misalign_o=1.
- Flush: flush_i in first BUSY cycle of LW -> request held until ack, valid_o=1, we_o=0.
- Reset asserted during BUSY -> all outputs 0 immediately; later ack ignored; ALU pass-through resumes with latency 1.
